// File: rtl/ritc_storage_readout.sv
// ritc_storage_readout
// Readout engine for the RITC sample storage. It waits for a readable
// event, sets the storage read address, then streams every sample word on
// a valid/ready port. Finally it releases the buffer with a clear write
// that keeps the trigger-enable bits.
// Optional feature: define RITC_READOUT_HEADER_EN to prefix each event with
// a header beat {16'hA55A, event_count_o}.
module ritc_storage_readout #(
   parameter int NWORDS        = 3072,
   parameter int RD_LATENCY    = 2,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic        user_clk_i,
   input  logic        reset,
   input  logic        enable_i,
   input  logic [1:0]  trig_en_i,
   input  logic        read_safe_i,
   input  logic [31:0] sample_dat_i,
   output logic        user_sel_o,
   output logic        sample_sel_o,
   output logic        user_wr_o,
   output logic        user_rd_o,
   output logic [11:0] user_addr_o,
   output logic [31:0] user_dat_o,
   output logic [31:0] m_tdata_o,
   output logic        m_tvalid_o,
   output logic        m_tlast_o,
   input  logic        m_tready_i,
   output logic        busy_o,
   output logic [15:0] event_count_o
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_SETADDR = 4'd1,
      ST_HEADER  = 4'd2,
      ST_WAIT    = 4'd3,
      ST_CAPTURE = 4'd4,
      ST_PUSH    = 4'd5,
      ST_STEP    = 4'd6,
      ST_RELEASE = 4'd7,
      ST_SETTLE  = 4'd8
   } state_t;

   localparam logic [11:0] LAST_WORD   = 12'(NWORDS - 1);
   localparam logic [15:0] WAIT_LAST   = 16'(RD_LATENCY - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   state_t        state_r;
   state_t        state_s;
   logic [15:0]   timer_r;
   logic [11:0]   word_cnt_r;
   logic          accept_s;

   logic          user_sel_r;
   logic          sample_sel_r;
   logic          user_wr_r;
   logic          user_rd_r;
   logic [11:0]   user_addr_r;
   logic [31:0]   user_dat_r;
   logic [31:0]   m_tdata_r;
   logic          m_tvalid_r;
   logic          m_tlast_r;
   logic          busy_r;
   logic [15:0]   event_count_r;

   assign accept_s = m_tvalid_r && m_tready_i;

   // State register.
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; ST_STEP is the one-cycle address-advance strobe between words.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable_i && read_safe_i) begin
               state_s = ST_SETADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETADDR: begin
`ifdef RITC_READOUT_HEADER_EN
            state_s = ST_HEADER;
`else
            state_s = ST_WAIT;
`endif
         end
         ST_HEADER: begin
            if (accept_s) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_HEADER;
            end
         end
         ST_WAIT: begin
            if (timer_r == WAIT_LAST) begin
               state_s = ST_CAPTURE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_CAPTURE: begin
            state_s = ST_PUSH;
         end
         ST_PUSH: begin
            if (accept_s && m_tlast_r) begin
               state_s = ST_RELEASE;
            end else if (accept_s) begin
               state_s = ST_STEP;
            end else begin
               state_s = ST_PUSH;
            end
         end
         ST_STEP: begin
            state_s = ST_WAIT;
         end
         ST_RELEASE: begin
            state_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (timer_r == SETTLE_LAST) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_SETTLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Per-state cycle timer, restarted on every state change.
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         timer_r <= 16'd0;
      end else if (state_s != state_r) begin
         timer_r <= 16'd0;
      end else begin
         timer_r <= timer_r + 16'd1;
      end
   end

   // Sample word counter: cleared when the address is set, advanced with each read strobe.
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         word_cnt_r <= 12'd0;
      end else if (state_s == ST_SETADDR) begin
         word_cnt_r <= 12'd0;
      end else if (state_s == ST_STEP) begin
         word_cnt_r <= word_cnt_r + 12'd1;
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

   // Registered outputs, decoded from the next state so strobes line up with their state.
   always_ff @(posedge user_clk_i) begin
      if (reset) begin
         user_sel_r    <= 1'b0;
         sample_sel_r  <= 1'b0;
         user_wr_r     <= 1'b0;
         user_rd_r     <= 1'b0;
         user_addr_r   <= 12'd0;
         user_dat_r    <= 32'd0;
         m_tdata_r     <= 32'd0;
         m_tvalid_r    <= 1'b0;
         m_tlast_r     <= 1'b0;
         busy_r        <= 1'b0;
         event_count_r <= 16'd0;
      end else begin
         user_sel_r   <= (state_s == ST_RELEASE);
         sample_sel_r <= (state_s == ST_SETADDR) || (state_s == ST_STEP);
         user_wr_r    <= (state_s == ST_SETADDR) || (state_s == ST_RELEASE);
         user_rd_r    <= (state_s == ST_STEP);
         user_addr_r  <= 12'd0;
         user_dat_r   <= (state_s == ST_RELEASE) ? {26'd0, trig_en_i, 4'b0100} : 32'd0;
         busy_r       <= (state_s != ST_IDLE);
         m_tvalid_r   <= (state_s == ST_PUSH) || (state_s == ST_HEADER);
         if (state_r == ST_CAPTURE) begin
            m_tdata_r <= sample_dat_i;
            m_tlast_r <= (word_cnt_r == LAST_WORD);
         end else if ((state_r == ST_SETADDR) && (state_s == ST_HEADER)) begin
            m_tdata_r <= {16'hA55A, event_count_r};
            m_tlast_r <= 1'b0;
         end else begin
            m_tdata_r <= m_tdata_r;
            m_tlast_r <= m_tlast_r;
         end
         if (state_s == ST_RELEASE) begin
            event_count_r <= event_count_r + 16'd1;
         end else begin
            event_count_r <= event_count_r;
         end
      end
   end

   assign user_sel_o    = user_sel_r;
   assign sample_sel_o  = sample_sel_r;
   assign user_wr_o     = user_wr_r;
   assign user_rd_o     = user_rd_r;
   assign user_addr_o   = user_addr_r;
   assign user_dat_o    = user_dat_r;
   assign m_tdata_o     = m_tdata_r;
   assign m_tvalid_o    = m_tvalid_r;
   assign m_tlast_o     = m_tlast_r;
   assign busy_o        = busy_r;
   assign event_count_o = event_count_r;

endmodule
